// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package     : div_pkg                                              |
// | Description : Shared constants and FSM state encoding for the      |
// |               32-bit iterative restoring divider (div_rem_32).     |
// | Contents    : c_WIDTH_DEF  - default operand/result width          |
// |               c_ITER_COUNT - restoring steps per division          |
// |               c_LATENCY    - start-accept to finish edge count     |
// |               state_t      - divider FSM states                    |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package div_pkg;

   localparam int c_WIDTH_DEF  = 32;
   localparam int c_ITER_COUNT = 32;
   localparam int c_LATENCY    = 34;

   // Last counter value seen in ITER; the step taken at this value is the final one.
   localparam logic [5:0] c_CNT_LAST = 6'(c_ITER_COUNT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : div_step                                             |
// | Description : One combinational restoring-division step.           |
// |               {rem, dvd} is shifted left by one, the divisor is    |
// |               trial-subtracted from the widened remainder, and the |
// |               new quotient bit enters the dividend LSB.            |
// | Ports       : i_rem      - partial remainder (magnitude)           |
// |               i_dvd      - dividend / quotient shift register      |
// |               i_dvs      - divisor magnitude                       |
// |               o_rem_next - remainder after the step                |
// |               o_dvd_next - shift register after the step           |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = c_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_dvd,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem_next,
   output logic [WIDTH-1:0] o_dvd_next
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;
   logic           w_qbit;

   // The shifted remainder needs one extra bit: rem < divisor before the
   // shift, so 2*rem+1 can exceed WIDTH bits but never WIDTH+1.
   assign w_shift    = {i_rem, i_dvd[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, i_dvs};
   assign w_qbit     = ~w_trial[WIDTH];
   assign o_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign o_dvd_next = {i_dvd[WIDTH-2:0], w_qbit};

endmodule : div_step
`default_nettype wire

// File: rtl/div_rem_32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : div_rem_32                                           |
// | Description : Fixed-latency iterative divider with RISC-V M        |
// |               semantics (DIV/DIVU/REM/REMU). Result valid 34       |
// |               edges after the edge that accepts start.             |
// | Ports       : clk           - clock, rising edge                   |
// |               reset         - synchronous, active-low              |
// |               start         - launch request (IDLE/DONE only)      |
// |               is_signed     - 1 = signed, 0 = unsigned             |
// |               a_net, b_net  - dividend, divisor                    |
// |               quotient_net  - quotient result                      |
// |               remainder_net - remainder result                     |
// |               busy          - operation in progress                |
// |               finish_net    - results valid                        |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module div_rem_32
   import div_pkg::*;
#(
   parameter int WIDTH = c_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a_net,
   input  logic [WIDTH-1:0] b_net,
   output logic [WIDTH-1:0] quotient_net,
   output logic [WIDTH-1:0] remainder_net,
   output logic             busy,
   output logic             finish_net
);

   state_t           r_state;
   state_t           w_next_state;

   logic             r_signed;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_rem;
   logic             r_q_neg;
   logic             r_r_neg;
   logic             r_div0;
   logic [5:0]       r_cnt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_busy;
   logic             r_finish;

   logic             w_start_ok;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_step_rem;
   logic [WIDTH-1:0] w_step_dvd;

   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_a_neg    = r_signed & r_a[WIDTH-1];
   assign w_b_neg    = r_signed & r_b[WIDTH-1];

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem      (r_rem),
      .i_dvd      (r_dvd),
      .i_dvs      (r_dvs),
      .o_rem_next (w_step_rem),
      .o_dvd_next (w_step_dvd)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_PREP;
         S_PREP:  w_next_state = S_ITER;
         S_ITER:  if (r_cnt == c_CNT_LAST) w_next_state = S_FIX;
         S_FIX:   w_next_state = S_DONE;
         S_DONE:  if (start) w_next_state = S_PREP;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_signed    <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_dvd       <= '0;
         r_dvs       <= '0;
         r_rem       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_div0      <= 1'b0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_busy      <= 1'b0;
         r_finish    <= 1'b0;
      end else begin
         r_state <= w_next_state;

         if (w_start_ok) begin
            r_a      <= a_net;
            r_b      <= b_net;
            r_signed <= is_signed;
            r_busy   <= 1'b1;
            r_finish <= 1'b0;
         end

         case (r_state)
            S_PREP: begin
               // Negating 0x80000000 wraps to itself, which is also its correct
               // unsigned magnitude, so the overflow case needs no special path.
               r_dvd   <= w_a_neg ? -r_a : r_a;
               r_dvs   <= w_b_neg ? -r_b : r_b;
               r_q_neg <= w_a_neg ^ w_b_neg;
               r_r_neg <= w_a_neg;
               r_div0  <= (r_b == '0);
               r_rem   <= '0;
               r_cnt   <= '0;
            end
            S_ITER: begin
               r_rem <= w_step_rem;
               r_dvd <= w_step_dvd;
               r_cnt <= r_cnt + 6'd1;
            end
            S_FIX: begin
               // Division by zero leaves an all-ones quotient from the step
               // logic; it must stay all-ones regardless of operand signs.
               r_quotient  <= (r_q_neg && !r_div0) ? -r_dvd : r_dvd;
               r_remainder <= r_r_neg ? -r_rem : r_rem;
               r_busy      <= 1'b0;
               r_finish    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign quotient_net  = r_quotient;
   assign remainder_net = r_remainder;
   assign busy          = r_busy;
   assign finish_net    = r_finish;

endmodule : div_rem_32
`default_nettype wire
